// File: rtl/console_pkg.sv
// Shared definitions for the console text writer: control codes, FSM states,
// reset attribute and the logical-to-physical cell address mapping.
package console_pkg;

    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_FF    = 8'h0C;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_ESC   = 8'h1B;
    localparam logic [7:0] CHR_SPACE = 8'h20;

    // Light grey on black, no blink.
    localparam logic [7:0] DEFAULT_ATTR = 8'h07;

    typedef enum logic [1:0] {
        IDLE,
        ESC,
        CLEAR_LINE,
        CLEAR_SCREEN
    } state_e;

    // Screen row -> buffer row via the circular top pointer. top and row are
    // both < rows, so one conditional subtract replaces the modulo.
    function automatic int phys_addr(input int top, input int row, input int col,
                                     input int cols, input int rows);
        int pr;
        pr = top + row;
        if (pr >= rows) pr = pr - rows;
        return pr * cols + col;
    endfunction

endpackage

// File: rtl/console_writer.sv
// Byte-stream terminal front end: interprets printable bytes and a small
// control-code set, tracks cursor/attribute/scroll and emits one
// {attr, char} cell write per cycle into the text buffer.
module console_writer #(
    parameter int         COLS         = 80,
    parameter int         ROWS         = 25,
    parameter logic [7:0] DEFAULT_ATTR = console_pkg::DEFAULT_ATTR,
    parameter int         ADDR_W       = 11,
    localparam int        CW           = $clog2(COLS),
    localparam int        RW           = $clog2(ROWS)
) (
    input  logic              clk_pixel,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [CW-1:0]     cursor_col,
    output logic [RW-1:0]     cursor_row,
    output logic [RW-1:0]     top_row,
    output logic [7:0]        attr
);
    import console_pkg::*;

    // Counter must reach COLS*ROWS itself: that value is the "done" marker
    // that holds in_ready low for one cycle past the last clear write.
    localparam int                CNT_W      = $clog2(COLS * ROWS + 1);
    localparam logic [CNT_W-1:0]  SCR_CELLS  = CNT_W'(COLS * ROWS);
    localparam logic [CNT_W-1:0]  LINE_CELLS = CNT_W'(COLS);
    localparam logic [CW-1:0]     LAST_COL   = CW'(COLS - 1);
    localparam logic [RW-1:0]     LAST_ROW   = RW'(ROWS - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [RW-1:0]       top_q, top_d;
    logic [RW-1:0]       clr_q, clr_d;
    logic [7:0]          attr_q, attr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                newline;

    // Next-state, cursor/scroll update and write-port generation.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        top_d     = top_q;
        clr_d     = clr_q;
        attr_d    = attr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        newline   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_byte >= CHR_SPACE) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ADDR_W'(phys_addr(int'(top_q), int'(row_q), int'(col_q), COLS, ROWS));
                        wr_data_d = {attr_q, in_byte};
                        if (col_q == LAST_COL) begin
                            col_d   = '0;
                            newline = 1'b1;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else begin
                        case (in_byte)
                            CHR_CR:  col_d = '0;
                            CHR_LF:  newline = 1'b1;
                            CHR_BS:  if (col_q != '0) col_d = col_q - CW'(1);
                            CHR_FF: begin
                                state_d = CLEAR_SCREEN;
                                top_d   = '0;
                                row_d   = '0;
                                col_d   = '0;
                                cnt_d   = '0;
                            end
                            CHR_ESC: state_d = ESC;
                            default: ;
                        endcase
                    end

                    if (newline) begin
                        if (row_q != LAST_ROW) begin
                            row_d = row_q + RW'(1);
                        end else begin
                            clr_d   = top_q;
                            top_d   = (top_q == LAST_ROW) ? '0 : top_q + RW'(1);
                            state_d = CLEAR_LINE;
                            if (wr_en_d) begin
                                // Write port busy with the character; clear starts next cycle.
                                cnt_d = '0;
                            end else begin
                                // Bare LF: first blank cell goes out in the accept cycle.
                                wr_en_d   = 1'b1;
                                wr_addr_d = ADDR_W'(phys_addr(int'(top_q), 0, 0, COLS, ROWS));
                                wr_data_d = {attr_q, CHR_SPACE};
                                cnt_d     = CNT_W'(1);
                            end
                        end
                    end
                end
            end

            ESC: begin
                if (in_valid) begin
                    attr_d  = in_byte;
                    state_d = IDLE;
                end
            end

            CLEAR_LINE: begin
                if (cnt_q == LINE_CELLS) begin
                    state_d = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_W'(phys_addr(int'(clr_q), 0, int'(cnt_q), COLS, ROWS));
                    wr_data_d = {attr_q, CHR_SPACE};
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end

            CLEAR_SCREEN: begin
                if (cnt_q == SCR_CELLS) begin
                    state_d = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_W'(cnt_q);
                    wr_data_d = {attr_q, CHR_SPACE};
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = CLEAR_SCREEN;
        endcase
    end

    // State and output registers; reset restarts a full-screen clear.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR_SCREEN;
            col_q     <= '0;
            row_q     <= '0;
            top_q     <= '0;
            clr_q     <= '0;
            attr_q    <= DEFAULT_ATTR;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            top_q     <= top_d;
            clr_q     <= clr_d;
            attr_q    <= attr_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign in_ready   = (state_q == IDLE) || (state_q == ESC);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign top_row    = top_q;
    assign attr       = attr_q;

endmodule

// File: tb/tb_console_writer.sv
// Directed bench for console_writer: clears, printing, escapes, scrolling,
// wrap of the top-row pointer and reset in the middle of a line clear.
module tb_console_writer;

    logic        clk_pixel = 1'b0;
    logic        reset_n   = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [7:0]  in_byte   = 8'h00;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [15:0] wr_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [4:0]  top_row;
    logic [7:0]  attr;

    int chk_cnt = 0;
    int err_cnt = 0;

    // captured write of the cycle after an accepted byte
    logic        w_en;
    logic [10:0] w_addr;
    logic [15:0] w_data;

    // clear_watch results
    int nwr, bad, nrdy, rdy, first;

    always #5 clk_pixel = ~clk_pixel;

    console_writer #(
        .COLS(80), .ROWS(25), .DEFAULT_ATTR(8'h07), .ADDR_W(11)
    ) dut (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
        .top_row   (top_row),
        .attr      (attr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents b, waits for the accepting edge, then
    // samples the write port in the following cycle.
    task automatic send(input logic [7:0] b);
        int k = 0;
        while (!in_ready && k < 300) begin
            @(negedge clk_pixel);
            k++;
        end
        if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
        in_byte  = b;
        in_valid = 1'b1;
        @(posedge clk_pixel);
        #1 in_valid = 1'b0;
        @(negedge clk_pixel);
        w_en   = wr_en;
        w_addr = wr_addr;
        w_data = wr_data;
    endtask

    // Samples from the current negedge until in_ready rises, checking each
    // write against base+k / data.
    task automatic clear_watch(input int base, input logic [15:0] data, input int budget);
        nwr = 0; bad = 0; nrdy = 0; rdy = -1; first = -1;
        for (int c = 0; c < budget; c++) begin
            if (wr_en) begin
                if (int'(wr_addr) != base + nwr || wr_data != data) bad++;
                if (first < 0) first = c;
                nwr++;
            end
            if (in_ready) begin
                rdy = c;
                break;
            end
            nrdy++;
            @(negedge clk_pixel);
        end
        if (rdy < 0) chk("clear_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n, agg;

        // reset state
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {21'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_cursor", {20'd0, cursor_row, cursor_col}, 32'd0);
        chk("rst_top", {27'd0, top_row}, 32'd0);
        chk("rst_attr", {24'd0, attr}, 32'h07);

        // power-on full clear
        reset_n = 1'b1;
        clear_watch(0, 16'h0720, 2100);
        chk("scr_writes", nwr, 2000);
        chk("scr_bad", bad, 0);
        chk("scr_ready_after", rdy, 2001);
        chk("scr_cursor", {20'd0, cursor_row, cursor_col}, 32'd0);

        // printable bytes
        send(8'h41);
        chk("A_wr", {w_en, 4'd0, w_addr, w_data}, {1'b1, 4'd0, 11'd0, 16'h0741});
        send(8'h42);
        chk("B_wr", {w_en, 4'd0, w_addr, w_data}, {1'b1, 4'd0, 11'd1, 16'h0742});
        chk("B_col", {25'd0, cursor_col}, 32'd2);

        // escape sets attribute, no writes
        send(8'h1B);
        chk("esc_nowr", {31'd0, w_en}, 32'd0);
        send(8'h1F);
        chk("escarg_nowr", {31'd0, w_en}, 32'd0);
        chk("esc_attr", {24'd0, attr}, 32'h1F);
        send(8'h78);
        chk("x_wr", {w_en, 4'd0, w_addr, w_data}, {1'b1, 4'd0, 11'd2, 16'h1F78});

        // full row of 80 printable bytes from col 0 wraps to next row
        send(8'h0D);
        chk("cr_col", {25'd0, cursor_col}, 32'd0);
        agg = 0;
        for (int i = 0; i < 80; i++) begin
            send(8'h41 + 8'(i % 26));
            if (!w_en || int'(w_addr) != i || w_data != {8'h1F, 8'h41 + 8'(i % 26)}) agg++;
        end
        chk("row_bad", agg, 0);
        chk("row_last", {5'd0, w_addr, w_data}, {5'd0, 11'd79, 16'h1F42});
        chk("row_cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd1, 7'd0});
        send(8'h0D);
        send(8'h08);
        send(8'h08);
        chk("bs_col0", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd1, 7'd0});

        // LF keeps column, BS steps back once then sticks at 0
        send(8'h71);
        chk("q_wr", {w_en, 4'd0, w_addr, w_data}, {1'b1, 4'd0, 11'd80, 16'h1F71});
        send(8'h0A);
        chk("lf_keep_col", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd2, 7'd1});
        send(8'h08);
        send(8'h08);
        chk("bs_stop", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd2, 7'd0});
        send(8'h0D);
        for (int i = 0; i < 22; i++) send(8'h0A);
        chk("row24", {20'd0, cursor_row, cursor_col, 5'd0, top_row}, {20'd0, 5'd24, 7'd0, 5'd0, 5'd0});

        // scroll on LF at bottom: clear physical row 0
        send(8'h0A);
        chk("scroll_top", {27'd0, top_row}, 32'd1);
        clear_watch(0, 16'h1F20, 200);
        chk("cl_writes", nwr, 80);
        chk("cl_bad", bad, 0);
        chk("cl_notready", nrdy, 80);
        chk("cl_cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd24, 7'd0});
        send(8'h5A);
        chk("Z_wr", {w_en, 4'd0, w_addr, w_data}, {1'b1, 4'd0, 11'd0, 16'h1F5A});

        // 24 more scrolls: top pointer walks 1..24 and wraps to 0
        send(8'h0D);
        agg = 0;
        for (int i = 0; i < 24; i++) begin
            send(8'h0A);
            clear_watch((1 + i) * 80, 16'h1F20, 200);
            if (nwr != 80 || bad != 0) agg++;
        end
        chk("wrap_clears", agg, 0);
        chk("wrap_top", {27'd0, top_row}, 32'd0);

        // printable at last cell: char at N+1, line clear from N+2
        agg = 0;
        for (int i = 0; i < 80; i++) begin
            send(8'h30 + 8'(i % 10));
            if (!w_en || int'(w_addr) != 1920 + i) agg++;
        end
        chk("last_row_bad", agg, 0);
        chk("last_cell", {5'd0, w_addr, w_data}, {5'd0, 11'd1999, 16'h1F39});
        @(negedge clk_pixel);
        clear_watch(0, 16'h1F20, 200);
        chk("eol_first", first, 0);
        chk("eol_writes", nwr, 80);
        chk("eol_bad", bad, 0);
        chk("eol_top", {27'd0, top_row}, 32'd1);

        // reset in the middle of a line clear
        send(8'h0A);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            if (wr_en) n++;
            if (n == 40) break;
            @(negedge clk_pixel);
        end
        chk("mid_reach40", n, 40);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wr", {wr_en, 4'd0, wr_addr, wr_data}, 32'd0);
        chk("mid_rst_state", {in_ready, 2'd0, top_row, cursor_row, cursor_col, attr},
            {1'b0, 2'd0, 5'd0, 5'd0, 7'd0, 8'h07});
        @(negedge clk_pixel);
        reset_n = 1'b1;
        clear_watch(0, 16'h0720, 2100);
        chk("rescr_writes", nwr, 2000);
        chk("rescr_bad", bad, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
